// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1101 stimulus generator and its reference model.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] SEQ_1101 = 4'b1101;
  localparam int         SEQ_LEN  = 4;

endpackage

// File: rtl/seq_match_model.sv
// Golden Mealy model of an overlapping 1101 detector: tracks the last four
// transmitted bits and flags the cycle carrying the fourth bit of each hit.
module seq_match_model
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               abort,
  input  logic               valid,
  input  logic               x,
  output logic [SEQ_LEN-1:0] hist,
  output logic               z_exp,
  output logic [CNT_W-1:0]   match_cnt
);

  // hist excludes the bit currently on x, so the window is hist[2:0] plus x
  assign z_exp = valid & ({hist[SEQ_LEN-2:0], x} == SEQ_1101);

  // Bit history: cleared by start or abort, shifts only on valid bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
    end else if (abort || clear) begin
      hist <= '0;
    end else if (valid) begin
      hist <= {hist[SEQ_LEN-2:0], x};
    end
  end

  // Hit counter: held across abort, cleared by start, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt <= '0;
    end else if (abort) begin
      match_cnt <= match_cnt;
    end else if (clear) begin
      match_cnt <= '0;
    end else if (z_exp && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_gen_1101.sv
// Serial 1101 stimulus transmitter: shifts a captured pattern out MSB-first,
// optionally repeating with no gap, alongside the expected detector response.
module seq_gen_1101
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic             start,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx,
  output logic [3:0]       hist,
  output logic             z_exp,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shadow, shadow_next;
  // sreg holds the bits still to be sent after the one on x
  logic [WIDTH-1:0] sreg, sreg_next;
  logic             x_next;
  logic [IDX_W-1:0] idx_next;
  logic             start_ok;

  // State, pattern and serial output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shadow  <= '0;
      sreg    <= '0;
      x       <= 1'b0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      shadow  <= shadow_next;
      sreg    <= sreg_next;
      x       <= x_next;
      bit_idx <= idx_next;
    end
  end

  // Next-state and next-bit selection; abort overrides every other control
  always_comb begin
    state_next  = state;
    shadow_next = shadow;
    sreg_next   = sreg;
    x_next      = 1'b0;
    idx_next    = '0;
    start_ok    = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (load) shadow_next = pattern;
          if (start) begin
            // Uses shadow_next so a same-cycle load is transmitted at once
            start_ok   = 1'b1;
            state_next = SHIFT;
            x_next     = shadow_next[WIDTH-1];
            sreg_next  = {shadow_next[WIDTH-2:0], 1'b0};
          end
        end
        SHIFT: begin
          if (bit_idx == LAST_IDX) begin
            if (repeat_en) begin
              x_next    = shadow[WIDTH-1];
              sreg_next = {shadow[WIDTH-2:0], 1'b0};
            end else begin
              state_next = DONE;
            end
          end else begin
            x_next    = sreg[WIDTH-1];
            sreg_next = {sreg[WIDTH-2:0], 1'b0};
            idx_next  = bit_idx + 1'b1;
          end
        end
        DONE: begin
          if (load) shadow_next = pattern;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign valid = (state == SHIFT);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

  seq_match_model #(
    .CNT_W(CNT_W)
  ) u_model (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .abort     (abort),
    .valid     (valid),
    .x         (x),
    .hist      (hist),
    .z_exp     (z_exp),
    .match_cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_gen_1101.sv
// Self-checking bench for seq_gen_1101: a bit-list model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_seq_gen_1101;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] pattern = '0;
  logic        start = 1'b0;
  logic        repeat_en = 1'b0;
  logic        abort = 1'b0;

  logic       x_a, valid_a, busy_a, done_a, z_a;
  logic [3:0] bit_idx_a, hist_a;
  logic [7:0] cnt_a;
  logic       x_b, valid_b, busy_b, done_b, z_b;
  logic [3:0] bit_idx_b, hist_b;
  logic [2:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: transmission position, shadow pattern, bits sent since start
  bit          m_shift = 0;
  bit          m_done  = 0;
  int          m_idx   = 0;
  logic [15:0] m_pat   = '0;
  bit          m_hist[$];
  int          m_hits  = 0;

  // observation counters, written only by the compare process
  int vpos = 0;
  int done_cnt = 0;
  int xones = 0;
  int hit_pos[$];

  seq_gen_1101 #(.WIDTH(16), .IDX_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .load(load), .pattern(pattern), .start(start),
    .repeat_en(repeat_en), .abort(abort), .x(x_a), .valid(valid_a),
    .busy(busy_a), .done(done_a), .bit_idx(bit_idx_a), .hist(hist_a),
    .z_exp(z_a), .match_cnt(cnt_a)
  );

  seq_gen_1101 #(.WIDTH(16), .IDX_W(4), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .load(load), .pattern(pattern), .start(start),
    .repeat_en(repeat_en), .abort(abort), .x(x_b), .valid(valid_b),
    .busy(busy_b), .done(done_b), .bit_idx(bit_idx_b), .hist(hist_b),
    .z_exp(z_b), .match_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_x();
    if (!m_shift) return 1'b0;
    return m_pat[15 - m_idx];
  endfunction

  // hit = current bit completes 1,1,0,1 in the list of bits sent since start
  function automatic bit model_z();
    int n = m_hist.size();
    if (!m_shift || !model_x() || n < 3) return 1'b0;
    return (m_hist[n-3] == 1'b1) && (m_hist[n-2] == 1'b1) && (m_hist[n-1] == 1'b0);
  endfunction

  function automatic logic [3:0] model_hist();
    logic [3:0] h = '0;
    int n = m_hist.size();
    for (int i = 0; i < 4 && i < n; i++) h[i] = m_hist[n-1-i];
    return h;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_shift = 0; m_done = 0; m_idx = 0; m_pat = '0; m_hits = 0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    bit was_shift = m_shift;
    bit was_done  = m_done;
    bit cur_x     = model_x();
    bit cur_z     = model_z();
    if (abort) begin
      m_shift = 0; m_done = 0; m_idx = 0;
      m_hist.delete();
      return;
    end
    if (was_shift) begin
      if (cur_z) m_hits++;
      m_hist.push_back(cur_x);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
    end
    m_done = 0;
    if (!was_shift && load) m_pat = pattern;
    if (!was_shift && !was_done && start) begin
      m_hist.delete();
      m_hits = 0;
      m_shift = 1;
      m_idx = 0;
    end else if (was_shift) begin
      if (m_idx == 15) begin
        if (!repeat_en) begin
          m_shift = 0; m_done = 1;
        end
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic compare_all();
    bit ez = model_z();
    chk("x", x_a, model_x());
    chk("valid", valid_a, m_shift);
    chk("busy", busy_a, m_shift);
    chk("done", done_a, m_done);
    chk("bit_idx", bit_idx_a, m_shift ? m_idx : 0);
    chk("hist", hist_a, model_hist());
    chk("z_exp", z_a, ez);
    chk("match_cnt", cnt_a, sat(m_hits, 255));
    chk("z_exp_c3", z_b, ez);
    chk("match_cnt_c3", cnt_b, sat(m_hits, 7));
    if (valid_a) begin
      if (z_a) hit_pos.push_back(vpos);
      if (x_a) xones++;
      vpos++;
    end
    if (done_a) done_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_idx(input int k, input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (valid_a && bit_idx_a == 4'(k)) found = 1;
      else tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: bit_idx %0d not reached within budget, got %0d", name, k, bit_idx_a);
    end
  endtask

  task automatic begin_tx(input logic [15:0] p, input bit ld, input bit rpt);
    pattern = p; load = ld; start = 1'b1; repeat_en = rpt;
    tick();
    load = 1'b0; start = 1'b0;
  endtask

  initial begin
    int hb, vb, db, xb;
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    model_reset();
    run(2);
    chk("reset_outputs", {x_a, valid_a, busy_a, done_a, bit_idx_a, hist_a, z_a, cnt_a}, 0);
    reset = 1'b1;
    run(2);

    // single pass: hits at 3, 6, 11, 15; done 17 edges after start is driven
    hb = hit_pos.size(); vb = vpos; db = done_cnt;
    begin_tx(16'b1101101011011101, 1'b1, 1'b0);
    chk("p1_first_bit", {valid_a, x_a, bit_idx_a}, {1'b1, 1'b1, 4'd0});
    run(15);
    chk("p1_last_bit", {valid_a, bit_idx_a}, {1'b1, 4'd15});
    tick();
    chk("p1_done_n17", {done_a, valid_a, busy_a}, 3'b100);
    tick();
    chk("p1_done_width", done_a, 1'b0);
    run(3);
    chk("p1_hit_count", hit_pos.size() - hb, 4);
    if (hit_pos.size() - hb == 4) begin
      chk("p1_hit0", hit_pos[hb] - vb, 3);
      chk("p1_hit1", hit_pos[hb+1] - vb, 6);
      chk("p1_hit2", hit_pos[hb+2] - vb, 11);
      chk("p1_hit3", hit_pos[hb+3] - vb, 15);
    end
    chk("p1_match_cnt", cnt_a, 4);
    chk("p1_idle_out", {x_a, valid_a}, 2'b00);
    chk("p1_hist_held", hist_a, 4'b1101);

    // wrap detection: 1101 straddles each pass boundary
    hb = hit_pos.size(); vb = vpos; db = done_cnt;
    begin_tx(16'h8006, 1'b1, 1'b1);
    run(33);
    repeat_en = 1'b0;
    run(20);
    chk("wrap_valid_bits", vpos - vb, 48);
    chk("wrap_hit_count", hit_pos.size() - hb, 2);
    if (hit_pos.size() - hb == 2) begin
      chk("wrap_hit_pass2", hit_pos[hb] - vb, 16);
      chk("wrap_hit_pass3", hit_pos[hb+1] - vb, 32);
    end
    chk("wrap_match_cnt", cnt_a, 2);
    chk("wrap_done_once", done_cnt - db, 1);

    // saturation: 10 passes of DDDD, 4 hits each
    hb = hit_pos.size(); vb = vpos;
    begin_tx(16'hDDDD, 1'b1, 1'b1);
    run(145);
    repeat_en = 1'b0;
    run(20);
    chk("sat_valid_bits", vpos - vb, 160);
    chk("sat_hits", hit_pos.size() - hb, 40);
    chk("sat_cnt8", cnt_a, 40);
    chk("sat_cnt3", cnt_b, 7);

    // load/start while busy are ignored
    vb = vpos; db = done_cnt; xb = xones;
    begin_tx(16'h1234, 1'b1, 1'b0);
    run(3);
    pattern = 16'hFFFF; load = 1'b1; start = 1'b1;
    run(4);
    load = 1'b0; start = 1'b0;
    run(20);
    chk("busy_ctl_valid_bits", vpos - vb, 16);
    chk("busy_ctl_ones", xones - xb, 5);
    chk("busy_ctl_done", done_cnt - db, 1);
    xb = xones;
    begin_tx(16'hFFFF, 1'b0, 1'b0);
    run(20);
    chk("shadow_kept_ones", xones - xb, 5);

    // abort at bit 5 of 1101 0000 ...: one hit retained, no done
    vb = vpos; db = done_cnt;
    begin_tx(16'hD000, 1'b1, 1'b0);
    wait_idx(5, "abort_wait");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_out", {x_a, valid_a, busy_a, done_a, bit_idx_a, hist_a}, 0);
    chk("abort_cnt", cnt_a, 1);
    run(20);
    chk("abort_no_done", done_cnt - db, 0);
    chk("abort_bits", vpos - vb, 6);
    chk("abort_cnt_held", cnt_a, 1);

    // async reset between edges at bit 7
    begin_tx(16'hDDDD, 1'b1, 1'b0);
    wait_idx(7, "reset_wait");
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", {x_a, valid_a, busy_a, done_a, bit_idx_a, hist_a, z_a, cnt_a}, 0);
    chk("async_reset_cnt3", cnt_b, 0);
    tick();
    run(2);
    reset = 1'b1;
    hb = hit_pos.size(); vb = vpos; xb = xones;
    begin_tx(16'hFFFF, 1'b0, 1'b0);
    run(20);
    chk("reset_stream_bits", vpos - vb, 16);
    chk("reset_stream_ones", xones - xb, 0);
    chk("reset_stream_hits", hit_pos.size() - hb, 0);
    chk("reset_stream_cnt", cnt_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen_1101.md
Name: seq_gen_1101

Overview:
Serial stimulus transmitter for the 1101 sequence-detector family. Loads a parallel pattern and shifts it out MSB-first as a one-bit stream `x`, one bit per clock, with an optional seamless repeat. Runs a Mealy-aligned golden model alongside the stream: `z_exp` is exactly the `z` a correct overlapping 1101 detector must produce. `match_cnt` counts those hits.

Parameters:
- WIDTH, 16, pattern length in bits (>=4)
- IDX_W, 4, bit-index width, equal to clog2(WIDTH)
- CNT_W, 8, match counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- load  in  1  capture `pattern` into the shadow register; honoured only when not busy
- pattern  in  WIDTH  parallel pattern, MSB transmitted first
- start  in  1  begin transmission; honoured only in IDLE
- repeat_en  in  1  at the end of a pass, wrap to the MSB with no gap
- abort  in  1  stop immediately
- x  out  1  serial bit, registered
- valid  out  1  `x` carries a pattern bit this cycle
- busy  out  1  state is SHIFT
- done  out  1  one-cycle pulse after the last bit of a non-repeating pass
- bit_idx  out  IDX_W  index of the bit currently on `x` (0 = MSB)
- hist  out  4  last four transmitted bits, newest in bit 0
- z_exp  out  1  expected detector output for the current `x`
- match_cnt  out  CNT_W  z_exp hits since the last start

Behaviour:
- Reset: all outputs are 0, the shadow pattern is 0, and the state is IDLE.
- States:
  - IDLE → SHIFT when `start` is high.
  - SHIFT → SHIFT on each bit.
  - SHIFT → DONE after bit WIDTH-1 when `repeat_en` is 0.
  - SHIFT → SHIFT with `bit_idx` = 0 after bit WIDTH-1 when `repeat_en` is 1. `repeat_en` is sampled at that last bit.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on `abort`; `abort` has priority over everything.
- Latency: `start` sampled in IDLE at edge N puts bit MSB on `x` with `valid` = 1 from edge N+1. Bit k appears at edge N+1+k.
- `load` and `start` in the same IDLE cycle: the new pattern is captured and transmission starts with it.
- `load` while busy is ignored; the shadow register is unchanged. `start` while busy is ignored.
- `start` clears `hist` and `match_cnt`.
- Outside SHIFT: `x` = 0, `valid` = 0, `bit_idx` = 0.
- `hist` shifts only on valid bits. It persists across a repeat wrap, so matches that straddle the wrap are detected. It holds its value in DONE and IDLE until the next `start`.
- `z_exp` is combinational: `valid` & `x` & (`hist`[2:0] == 3'b110), where `hist` excludes the current bit. It is high in the same cycle as the fourth bit of each 1101 window; overlapping windows count.
- `match_cnt` increments on each `z_exp` and saturates at all-ones.
- `done` is high during the DONE cycle only.
- `abort` clears `x`, `valid` and `hist` on the next edge. It does not pulse `done`, and it leaves `match_cnt` holding its value.
- Async reset mid-stream: outputs drop to 0 immediately, regardless of the clock.

Decomposition:
- Shared package `seq_det_pkg`:
  - state enum {IDLE, SHIFT, DONE}
  - constant SEQ_1101 = 4'b1101
  - constant SEQ_LEN = 4
- One sub-module, `seq_match_model`: holds `hist`, `z_exp` and `match_cnt`. It is reusable by detector benches as the reference model.

Test Plan:
- Single pass: load 16'b1101101011011101, start, repeat_en = 0 → `z_exp` pulses at `bit_idx` 3, 6, 11 and 15; `match_cnt` = 4; `done` pulses at cycle N+17; `x` and `valid` are 0 afterwards.
- Wrap detection: load 16'b1000000000000110, repeat_en = 1, run 48 bit-cycles → no hit in the first pass; `z_exp` at `bit_idx` 0 of pass 2 and of pass 3; `match_cnt` = 2.
- Saturation: load 16'hDDDD, repeat_en = 1, CNT_W = 3, run 10 passes → 4 hits per pass; `match_cnt` sticks at 7.
- Ignored controls: `load` 16'hFFFF while busy and `start` while busy → the stream continues with the original pattern; only 16 valid bits and one `done`.
- Abort: assert `abort` at `bit_idx` 5 → next edge goes to IDLE with `x`, `valid` and `busy` at 0; no `done` pulse; `match_cnt` is retained.
- Reset: drive `reset` low at `bit_idx` 7 between clock edges → all outputs are 0 immediately; the shadow pattern reads 0 after release, so a start with no load transmits 16 zeros and `match_cnt` = 0.
